// File: rtl/bcd_sevenseg_scan.sv
// Three-digit multiplexed seven-segment driver fed from a binary-to-BCD converter.
// Loaded digits are double-buffered and only reach the display at a frame boundary.
module bcd_sevenseg_scan #(
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame_tick,
   output logic [1:0] state_dbg
);

   localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0]       SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]       AN_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {
      ST_HUND = 2'd0,
      ST_TENS = 2'd1,
      ST_UNIT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       active_q, active_d;
   logic [9:0]       pending_q, pending_d;
   logic             pend_valid_q, pend_valid_d;
   logic             boundary_q, boundary_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic             frame_tick_q, frame_tick_d;

   logic             digit_step;
   logic             frame_step;
   logic [3:0]       cur_digit;
   logic             blank_digit;
   logic [6:0]       seg_raw;
   logic [2:0]       an_raw;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h79;
      endcase
      return s;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HUND;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the digit FSM only moves on a prescaler wrap
   always_comb begin
      digit_step = (div_cnt_q == CNT_MAX);
      state_d    = state_q;
      if (digit_step) begin
         case (state_q)
            ST_HUND: state_d = ST_TENS;
            ST_TENS: state_d = ST_UNIT;
            ST_UNIT: state_d = ST_HUND;
            default: state_d = ST_HUND;
         endcase
      end
   end

   // Prescaler and double buffer; a load in the boundary cycle stays pending
   always_comb begin
      frame_step   = digit_step && (state_q == ST_UNIT);
      div_cnt_d    = digit_step ? '0 : div_cnt_q + 1'b1;
      active_d     = active_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      boundary_d   = frame_step;
      if (frame_step && pend_valid_q) begin
         active_d     = pending_q;
         pend_valid_d = 1'b0;
      end
      if (load) begin
         pending_d    = {hundreds, tens, units};
         pend_valid_d = 1'b1;
      end
   end

   // Output logic: segments and enables come from the same state so they switch together
   always_comb begin
      cur_digit   = 4'd0;
      blank_digit = 1'b0;
      an_raw      = 3'b000;
      case (state_q)
         ST_HUND: begin
            cur_digit   = {2'b00, active_q[9:8]};
            blank_digit = blank_lz && (active_q[9:8] == 2'd0);
            an_raw      = 3'b100;
         end
         ST_TENS: begin
            cur_digit   = active_q[7:4];
            blank_digit = blank_lz && (active_q[9:8] == 2'd0) && (active_q[7:4] == 4'd0);
            an_raw      = 3'b010;
         end
         ST_UNIT: begin
            cur_digit   = active_q[3:0];
            an_raw      = 3'b001;
         end
         default: begin
            blank_digit = 1'b1;
         end
      endcase
      seg_raw      = blank_digit ? 7'h00 : decode(cur_digit);
      seg_d        = ACTIVE_LOW ? ~seg_raw : seg_raw;
      an_d         = ACTIVE_LOW ? ~an_raw : an_raw;
      frame_tick_d = boundary_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q    <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         boundary_q   <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         boundary_q   <= boundary_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Bench for bcd_sevenseg_scan: two instances (active-high N=4, active-low N=3) checked
// every cycle against a frame-level model of what the display should show.
module tb_bcd_sevenseg_scan;

   localparam int N0 = 4;
   localparam int N1 = 3;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       load;
   logic [1:0] hundreds;
   logic [3:0] tens;
   logic [3:0] units;
   logic       blank_lz;

   logic [6:0] seg0, seg1;
   logic [2:0] an0, an1;
   logic       tick0, tick1;
   logic [1:0] st0, st1;

   bcd_sevenseg_scan #(.REFRESH_DIV(N0), .ACTIVE_LOW(1'b0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .hundreds(hundreds), .tens(tens),
      .units(units), .blank_lz(blank_lz), .seg(seg0), .an(an0),
      .frame_tick(tick0), .state_dbg(st0)
   );

   bcd_sevenseg_scan #(.REFRESH_DIV(N1), .ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .hundreds(hundreds), .tens(tens),
      .units(units), .blank_lz(blank_lz), .seg(seg1), .an(an1),
      .frame_tick(tick1), .state_dbg(st1)
   );

   // reference model state
   typedef struct {
      int         cyc;
      logic [9:0] val;
   } load_t;

   load_t      loads[$];
   logic [12:0] exp0_q[$];
   logic [12:0] exp1_q[$];
   int         checks = 0;
   int         errors = 0;
   int         t = 0;
   bit         prev_rst = 1'b0;
   bit         have_reset = 1'b0;
   logic       prev_blank = 1'b0;
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Value shown during display frame f: the last load strictly before that frame's boundary cycle
   function automatic logic [9:0] active_for(input int f, input int n);
      logic [9:0] v;
      int         b;
      v = '0;
      b = 3 * n * f;
      foreach (loads[i]) begin
         if (loads[i].cyc < b) v = loads[i].val;
      end
      return v;
   endfunction

   // Expected {state, tick, an, seg} for cycle t (t=1 is the first cycle after reset release)
   function automatic logic [12:0] expect_out(input int n, input bit al);
      int         d, s, f;
      logic [9:0] v;
      logic [3:0] digit;
      logic       blank;
      logic [6:0] sg;
      logic [2:0] a;
      logic       tk;
      logic [1:0] st;
      if (prev_rst) return {2'd0, 1'b0, (al ? 3'b111 : 3'b000), (al ? 7'h7F : 7'h00)};
      d     = t - 2;
      s     = (d / n) % 3;
      f     = d / (3 * n);
      v     = active_for(f, n);
      blank = 1'b0;
      if (s == 0) begin
         digit = {2'b00, v[9:8]};
         blank = prev_blank && (v[9:8] == 2'd0);
      end else if (s == 1) begin
         digit = v[7:4];
         blank = prev_blank && (v[9:8] == 2'd0) && (v[7:4] == 4'd0);
      end else begin
         digit = v[3:0];
      end
      if (blank)           sg = 7'h00;
      else if (digit > 9)  sg = 7'h79;
      else                 sg = seg_tab[digit];
      a  = 3'b100 >> s;
      tk = (d > 0) && (d % (3 * n) == 0);
      st = 2'(((t - 1) / n) % 3);
      if (al) begin
         sg = ~sg;
         a  = ~a;
      end
      return {st, tk, a, sg};
   endfunction

   // driver task: one clock cycle of stimulus; expectation for this cycle is queued first
   task automatic step(input bit r, input bit ld, input logic [9:0] v, input logic bl);
      @(posedge clk);
      #1;
      t = prev_rst ? 1 : t + 1;
      if (have_reset) begin
         exp0_q.push_back(expect_out(N0, 1'b0));
         exp1_q.push_back(expect_out(N1, 1'b1));
      end
      rst      = r;
      load     = ld;
      hundreds = v[9:8];
      tens     = v[7:4];
      units    = v[3:0];
      blank_lz = bl;
      if (r) begin
         loads.delete();
         have_reset = 1'b1;
      end else if (ld) begin
         loads.push_back('{t, v});
      end
      prev_rst   = r;
      prev_blank = bl;
   endtask

   task automatic idle(input int cycles, input logic bl);
      repeat (cycles) step(1'b0, 1'b0, 10'd0, bl);
   endtask

   // scoreboard monitor
   task automatic compare(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d: state/tick/an/seg got %0d/%b/%b/%h expected %0d/%b/%b/%h",
                  name, t, act[12:11], act[10], act[9:7], act[6:0],
                  exp[12:11], exp[10], exp[9:7], exp[6:0]);
      end
   endtask

   always @(negedge clk) begin
      if (exp0_q.size() > 0) compare("dut0_n4_ah", {st0, tick0, an0, seg0}, exp0_q.pop_front());
      if (exp1_q.size() > 0) compare("dut1_n3_al", {st1, tick1, an1, seg1}, exp1_q.pop_front());
   end

   initial begin
      logic [9:0] rv;
      rst = 1'b1; load = 1'b0; hundreds = '0; tens = '0; units = '0; blank_lz = 1'b0;

      // reset then basic load of 255 in the first cycle after release
      repeat (3) step(1'b1, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b1, {2'd2, 4'd5, 4'd5}, 1'b0);
      idle(30, 1'b0);

      // leading-zero blanking
      step(1'b0, 1'b1, {2'd0, 4'd0, 4'd7}, 1'b1);
      idle(26, 1'b1);
      step(1'b0, 1'b1, {2'd0, 4'd4, 4'd0}, 1'b1);
      idle(26, 1'b1);

      // two loads in one frame: only the second may appear
      step(1'b0, 1'b1, {2'd1, 4'd2, 4'd3}, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 1'b1, {2'd0, 4'd4, 4'd5}, 1'b0);
      idle(26, 1'b0);

      // load in the dut0 boundary cycle
      while ((t + 1) % (3 * N0) != 0) idle(1, 1'b0);
      step(1'b0, 1'b1, {2'd3, 4'd8, 4'd9}, 1'b0);
      idle(40, 1'b0);

      // invalid BCD is never blanked
      step(1'b0, 1'b1, {2'd0, 4'd12, 4'd15}, 1'b1);
      idle(26, 1'b1);

      // reset during the TENS slot with a load pending
      step(1'b1, 1'b0, 10'd0, 1'b0);
      step(1'b0, 1'b1, {2'd3, 4'd9, 4'd9}, 1'b0);
      while (t < 5) idle(1, 1'b0);
      step(1'b1, 1'b0, 10'd0, 1'b0);
      idle(30, 1'b0);

      // randomized traffic with occasional resets
      repeat (700) begin
         rv[9:8] = 2'($urandom_range(0, 3));
         rv[7:4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         rv[3:0] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) rv[9:4] = 6'd0;
         step(($urandom_range(0, 249) == 0), ($urandom_range(0, 6) == 0), rv,
              1'($urandom_range(0, 1)));
      end
      idle(2, 1'b0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
